// File: rtl/sc_spi_pkg.sv
//------------------------------------------------------------------------------
// sc_spi_pkg
// Shared constants for the SPI sequencer slice: the sequencer state encodings
// and the TX/RX word width.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package sc_spi_pkg;

   localparam int WORD_W = 32;

   localparam logic [1:0] seqIDLE  = 2'd0;
   localparam logic [1:0] seqLOAD  = 2'd1;
   localparam logic [1:0] seqSTART = 2'd2;
   localparam logic [1:0] seqWAIT  = 2'd3;

endpackage

// File: rtl/sc_spi_seq_if.sv
//------------------------------------------------------------------------------
// sc_spi_seq_if
// Bundles the sequencer's command, TX stream, RX stream, status and SPC-side
// signals. The master modport is the sequencer's view; slave is the view of
// the surrounding host and SPI protocol controller.
//   CMD_*      command handshake (word count minus one, keep-CS flag)
//   TXS_*      TX word stream into the sequencer
//   RXS_*      RX word stream out of the sequencer
//   SEQBUSY/SEQDONE  status
//   SPISTART/SPIBUSY/TXDATA/TXDETECT/RXDATA/RXVALID/CSEXTEND  SPC link
// Optional macro SC_SPI_SEQ_RXDISCARD_EN adds CMD_RXEN.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface sc_spi_seq_if #(
   parameter int CWIDTH = 8
);
   import sc_spi_pkg::*;

   logic                CMD_VALID;
   logic                CMD_READY;
   logic [CWIDTH-1:0]   CMD_WORDS;
   logic                CMD_KEEPCS;
`ifdef SC_SPI_SEQ_RXDISCARD_EN
   logic                CMD_RXEN;
`endif
   logic                TXS_VALID;
   logic                TXS_READY;
   logic [WORD_W-1:0]   TXS_DATA;
   logic                RXS_VALID;
   logic                RXS_READY;
   logic [WORD_W-1:0]   RXS_DATA;
   logic                SEQBUSY;
   logic                SEQDONE;
   logic                SPISTART;
   logic                SPIBUSY;
   logic [WORD_W-1:0]   TXDATA;
   logic                TXDETECT;
   logic [WORD_W-1:0]   RXDATA;
   logic                RXVALID;
   logic                CSEXTEND;

   modport master (
`ifdef SC_SPI_SEQ_RXDISCARD_EN
      input  CMD_RXEN,
`endif
      input  CMD_VALID, CMD_WORDS, CMD_KEEPCS, TXS_VALID, TXS_DATA,
             RXS_READY, SPIBUSY, TXDETECT, RXDATA, RXVALID,
      output CMD_READY, TXS_READY, RXS_VALID, RXS_DATA, SEQBUSY, SEQDONE,
             SPISTART, TXDATA, CSEXTEND
   );

   modport slave (
`ifdef SC_SPI_SEQ_RXDISCARD_EN
      output CMD_RXEN,
`endif
      output CMD_VALID, CMD_WORDS, CMD_KEEPCS, TXS_VALID, TXS_DATA,
             RXS_READY, SPIBUSY, TXDETECT, RXDATA, RXVALID,
      input  CMD_READY, TXS_READY, RXS_VALID, RXS_DATA, SEQBUSY, SEQDONE,
             SPISTART, TXDATA, CSEXTEND
   );

endinterface

// File: rtl/sc_spi_seq_fifo.sv
//------------------------------------------------------------------------------
// sc_spi_seq_fifo
// Synchronous RX word FIFO. A write into a full FIFO is accepted when a read
// happens in the same cycle. o_rdata presents the stored head word (0 when
// empty).
//   i_clk, i_rstb   clock, asynchronous active-low reset
//   i_wr, i_wdata   write request and word
//   i_rd            read request (ignored when empty)
//   o_rdata         head word
//   o_full, o_empty status flags
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module sc_spi_seq_fifo
   import sc_spi_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              i_clk,
   input  logic              i_rstb,
   input  logic              i_wr,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic              i_rd,
   output logic [WORD_W-1:0] o_rdata,
   output logic              o_full,
   output logic              o_empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;
   logic              w_rd;
   logic              w_wr;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign w_rd    = i_rd & ~o_empty;
   // A read in the same cycle frees the slot the write lands in.
   assign w_wr    = i_wr & (~o_full | w_rd);
   assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

   always_ff @(posedge i_clk or negedge i_rstb) begin
      if (!i_rstb) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wptr] <= i_wdata;
   end

endmodule

// File: rtl/sc_spi_seq.sv
//------------------------------------------------------------------------------
// sc_spi_seq
// Multi-word SPI transfer sequencer upstream of the SPI protocol controller.
// Takes a command (word count minus one, keep-CS flag), pulls one TX word per
// frame, issues one SPISTART handshake per word, holds CS across words with
// CSEXTEND and queues every received word in an RX FIFO.
//   SPICLK    clock
//   SYSRSTB   asynchronous active-low reset
//   io_spi    sc_spi_seq_if.master: command, TX/RX streams, status, SPC link
// Optional macro SC_SPI_SEQ_RXDISCARD_EN: CMD_RXEN=0 at command accept drops
// received words instead of queueing them (no FIFO-space stall either).
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module sc_spi_seq
   import sc_spi_pkg::*;
#(
   parameter int RXDEPTH = 2,
   parameter int CWIDTH  = 8
) (
   input  logic SPICLK,
   input  logic SYSRSTB,
   sc_spi_seq_if.master io_spi
);
   logic [1:0]        r_state;
   logic [CWIDTH-1:0] r_remain;
   logic              r_keep;
   logic [WORD_W-1:0] r_txdata;
   logic              r_spistart;
   logic              r_csext;
   logic              r_seqdone;
   logic              r_rxgot;
   logic              r_txdet_q;
   logic              r_rxval_q;
   logic              r_hist_vld;

   logic              w_tx_ack;
   logic              w_rx_ev;
   logic              w_cmd_rdy;
   logic              w_cmd_acc;
   logic              w_rxen;
   logic              w_space;
   logic              w_txs_rdy;
   logic              w_load_go;
   logic              w_wait_go;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [WORD_W-1:0] w_fifo_rdata;

`ifdef SC_SPI_SEQ_RXDISCARD_EN
   logic              r_rxen;
   assign w_rxen = r_rxen;
`else
   assign w_rxen = 1'b1;
`endif

   // The history registers come out of reset at 0 while the SPC toggles may
   // sit at 1; edges are ignored until they have been loaded once.
   assign w_tx_ack  = r_hist_vld & (io_spi.TXDETECT ^ r_txdet_q);
   assign w_rx_ev   = r_hist_vld & (io_spi.RXVALID ^ r_rxval_q);

   assign w_cmd_rdy = r_hist_vld & (r_state == seqIDLE) & ~io_spi.SPIBUSY;
   assign w_cmd_acc = w_cmd_rdy & io_spi.CMD_VALID;
   // A word only starts when its reply is guaranteed a FIFO slot.
   assign w_space   = ~w_rxen | ~w_fifo_full;
   assign w_txs_rdy = (r_state == seqLOAD) & w_space;
   assign w_load_go = w_txs_rdy & io_spi.TXS_VALID;
   assign w_wait_go = (r_state == seqWAIT) & r_rxgot & ~io_spi.SPIBUSY;

   assign io_spi.CMD_READY = w_cmd_rdy;
   assign io_spi.TXS_READY = w_txs_rdy;
   assign io_spi.RXS_VALID = ~w_fifo_empty;
   assign io_spi.RXS_DATA  = w_fifo_rdata;
   assign io_spi.SEQBUSY   = (r_state != seqIDLE);
   assign io_spi.SEQDONE   = r_seqdone;
   assign io_spi.SPISTART  = r_spistart;
   assign io_spi.TXDATA    = r_txdata;
   assign io_spi.CSEXTEND  = r_csext;

   sc_spi_seq_fifo #(
      .DEPTH   (RXDEPTH)
   ) u_fifo (
      .i_clk   (SPICLK),
      .i_rstb  (SYSRSTB),
      .i_wr    (w_rx_ev & w_rxen),
      .i_wdata (io_spi.RXDATA),
      .i_rd    (io_spi.RXS_READY),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         r_state    <= seqIDLE;
         r_remain   <= '0;
         r_keep     <= 1'b0;
         r_txdata   <= '0;
         r_spistart <= 1'b0;
         r_csext    <= 1'b0;
         r_seqdone  <= 1'b0;
         r_rxgot    <= 1'b0;
         r_txdet_q  <= 1'b0;
         r_rxval_q  <= 1'b0;
         r_hist_vld <= 1'b0;
`ifdef SC_SPI_SEQ_RXDISCARD_EN
         r_rxen     <= 1'b0;
`endif
      end else begin
         r_txdet_q  <= io_spi.TXDETECT;
         r_rxval_q  <= io_spi.RXVALID;
         r_hist_vld <= 1'b1;
         r_seqdone  <= 1'b0;
         if (w_rx_ev) r_rxgot <= 1'b1;

         case (r_state)
            seqIDLE: begin
               if (w_cmd_acc) begin
                  r_remain <= io_spi.CMD_WORDS;
                  r_keep   <= io_spi.CMD_KEEPCS;
`ifdef SC_SPI_SEQ_RXDISCARD_EN
                  r_rxen   <= io_spi.CMD_RXEN;
`endif
                  // CS left asserted only if the previous command asked for it.
                  if (!r_keep) r_csext <= 1'b0;
                  r_state  <= seqLOAD;
               end
            end
            seqLOAD: begin
               if (w_load_go) begin
                  r_txdata   <= io_spi.TXS_DATA;
                  r_rxgot    <= 1'b0;
                  r_spistart <= 1'b1;
                  r_csext    <= (r_remain != '0) | r_keep;
                  r_state    <= seqSTART;
               end
            end
            seqSTART: begin
               if (w_tx_ack) begin
                  r_spistart <= 1'b0;
                  r_state    <= seqWAIT;
               end
            end
            seqWAIT: begin
               // The end-of-frame TXDETECT toggle lands here and is ignored.
               if (w_wait_go) begin
                  if (r_remain == '0) begin
                     r_seqdone <= 1'b1;
                     r_state   <= seqIDLE;
                  end else begin
                     r_remain <= r_remain - 1'b1;
                     r_state  <= seqLOAD;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sc_spi_seq.sv
`timescale 1ns/1ps
module tb_sc_spi_seq;
   import sc_spi_pkg::*;

   localparam int CW  = 8;
   localparam int RXD = 2;

   logic SPICLK  = 1'b0;
   logic SYSRSTB = 1'b0;
   always #5 SPICLK = ~SPICLK;

   sc_spi_seq_if #(.CWIDTH(CW)) bus ();

   sc_spi_seq #(.RXDEPTH(RXD), .CWIDTH(CW)) dut (
      .SPICLK  (SPICLK),
      .SYSRSTB (SYSRSTB),
      .io_spi  (bus)
   );

`ifdef SC_SPI_SEQ_RXDISCARD_EN
   initial bus.CMD_RXEN = 1'b1;
`endif

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge SPICLK) cyc++;

   // Reference model state: the word stream the SPC must see, the CSEXTEND
   // level each word must carry, and the words the RX side must return.
   logic [31:0] tx_q[$];
   logic [31:0] exp_tx[$];
   logic        exp_cs[$];
   logic [31:0] exp_rx[$];
   int          latch_cyc[$];
   int          valid_cyc[$];
   logic [31:0] rx_xor = 32'h0;
   int          tx_delay = 0;
   int          rx_pct = 100;
   bit          rx_hold = 1'b0;
   int          done_cnt = 0;
   int          fall_cyc = -100;
   int          frame_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {bus.CMD_READY, bus.TXS_READY, bus.RXS_VALID, bus.SEQBUSY,
                          bus.SEQDONE, bus.SPISTART, bus.CSEXTEND}, 32'h0);
      chk({tag, "_txdata"}, bus.TXDATA, 32'h0);
      chk({tag, "_rxsdata"}, bus.RXS_DATA, 32'h0);
   endtask

   // ---------------- SPC model ----------------
   task automatic spc_frame();
      logic [31:0] w;
      bit stable;
      int len;
      repeat ($urandom_range(0, 2)) begin @(posedge SPICLK); #1; end
      if (!SYSRSTB) return;
      w = bus.TXDATA;
      frame_cnt++;
      latch_cyc.push_back(cyc);
      if (exp_tx.size() > 0) begin
         chk("tx_word", w, exp_tx.pop_front());
         chk("csextend", {31'h0, bus.CSEXTEND}, {31'h0, exp_cs.pop_front()});
      end else begin
         chk("tx_unexpected", {31'h0, bus.SPISTART}, 32'h0);
      end
      bus.TXDETECT = ~bus.TXDETECT;
      bus.SPIBUSY  = 1'b1;
      len = $urandom_range(3, 10);
      stable = 1'b1;
      for (int i = 0; i < len; i++) begin
         @(posedge SPICLK); #1;
         if (!SYSRSTB) begin
            bus.SPIBUSY = 1'b0;
            return;
         end
         if (bus.TXDATA !== w || bus.SPISTART !== 1'b0) stable = 1'b0;
      end
      chk("txdata_stable", {31'h0, stable}, 32'h1);
      bus.RXDATA   = w ^ rx_xor;
      bus.RXVALID  = ~bus.RXVALID;
      bus.TXDETECT = ~bus.TXDETECT;
      @(posedge SPICLK); #1;
      bus.SPIBUSY = 1'b0;
      fall_cyc = cyc;
   endtask

   initial begin
      bus.SPIBUSY  = 1'b0;
      bus.TXDETECT = 1'b0;
      bus.RXVALID  = 1'b0;
      bus.RXDATA   = 32'h0;
      forever begin
         @(posedge SPICLK); #1;
         if (SYSRSTB && bus.SPISTART && !bus.SPIBUSY) spc_frame();
      end
   end

   // ---------------- TX source ----------------
   initial begin
      bit take;
      int gap;
      bus.TXS_VALID = 1'b0;
      bus.TXS_DATA  = 32'h0;
      gap = 0;
      forever begin
         @(negedge SPICLK);
         take = SYSRSTB && bus.TXS_VALID && bus.TXS_READY;
         @(posedge SPICLK); #1;
         if (!SYSRSTB) begin
            bus.TXS_VALID = 1'b0;
            gap = 0;
         end else begin
            if (take) begin
               if (tx_q.size() > 0) void'(tx_q.pop_front());
               bus.TXS_VALID = 1'b0;
               gap = tx_delay;
            end
            if (!bus.TXS_VALID && tx_q.size() > 0) begin
               if (gap > 0) gap--;
               else begin
                  bus.TXS_VALID = 1'b1;
                  bus.TXS_DATA  = tx_q[0];
                  valid_cyc.push_back(cyc);
               end
            end
         end
      end
   end

   // ---------------- RX sink and monitors ----------------
   initial begin
      bus.RXS_READY = 1'b0;
      forever begin
         @(posedge SPICLK); #1;
         bus.RXS_READY = !rx_hold && ($urandom_range(0, 99) < rx_pct);
      end
   end

   initial forever begin
      @(negedge SPICLK);
      if (SYSRSTB && bus.RXS_VALID && bus.RXS_READY) begin
         if (exp_rx.size() > 0) chk("rx_word", bus.RXS_DATA, exp_rx.pop_front());
         else chk("rx_unexpected", {31'h0, bus.RXS_VALID}, 32'h0);
      end
   end

   initial forever begin
      @(negedge SPICLK);
      if (bus.SEQDONE) begin
         done_cnt++;
         chk("seqdone_latency", cyc - fall_cyc, 32'd1);
      end
   end

   // ---------------- command helpers ----------------
   task automatic run_cmd(input int n, input bit keep, input logic [31:0] base);
      logic [31:0] w;
      int t;
      for (int i = 0; i < n; i++) begin
         w = (base != 32'h0) ? base + 32'(i) : $urandom;
         tx_q.push_back(w);
         exp_tx.push_back(w);
         exp_cs.push_back((i < n - 1) ? 1'b1 : keep);
         exp_rx.push_back(w ^ rx_xor);
      end
      @(posedge SPICLK); #1;
      bus.CMD_VALID  = 1'b1;
      bus.CMD_WORDS  = CW'(n - 1);
      bus.CMD_KEEPCS = keep;
      t = 0;
      @(negedge SPICLK);
      while (!bus.CMD_READY && t < 2000) begin
         @(negedge SPICLK);
         t++;
      end
      if (t >= 2000) chk("cmd_accept_timeout", {31'h0, bus.CMD_READY}, 32'h1);
      @(posedge SPICLK); #1;
      bus.CMD_VALID = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int t;
      t = 0;
      while (done_cnt < target && t < 3000) begin
         @(posedge SPICLK);
         t++;
      end
      chk("seqdone_count", done_cnt, target);
      t = 0;
      while (exp_rx.size() > 0 && t < 2000) begin
         @(posedge SPICLK);
         t++;
      end
      chk("rx_drained", exp_rx.size(), 32'h0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int fc0, t, dn;
      bus.CMD_VALID  = 1'b0;
      bus.CMD_WORDS  = '0;
      bus.CMD_KEEPCS = 1'b0;
      repeat (3) @(posedge SPICLK);
      #1 chk_all_zero("reset");
      @(negedge SPICLK); #2 SYSRSTB = 1'b1;
      @(negedge SPICLK);
      chk("cmd_ready_idle", {31'h0, bus.CMD_READY}, 32'h1);

      // single word, loopback
      frame_cnt = 0;
      run_cmd(1, 1'b0, 32'hA5A5_0001);
      wait_done(1);
      chk("single_frames", frame_cnt, 32'd1);
      chk("single_cs_after", {31'h0, bus.CSEXTEND}, 32'h0);

      // four words 1..4
      frame_cnt = 0;
      run_cmd(4, 1'b0, 32'h1);
      wait_done(2);
      chk("four_frames", frame_cnt, 32'd4);
      chk("four_cs_after", {31'h0, bus.CSEXTEND}, 32'h0);

      // RX back-pressure: only FIFO-depth words may start
      rx_hold = 1'b1;
      frame_cnt = 0;
      run_cmd(5, 1'b0, 32'h0);
      repeat (300) @(posedge SPICLK);
      @(negedge SPICLK);
      chk("stall_frames", frame_cnt, RXD);
      chk("stall_txs_ready", {31'h0, bus.TXS_READY}, 32'h0);
      chk("stall_rxs_valid", {31'h0, bus.RXS_VALID}, 32'h1);
      rx_hold = 1'b0;
      wait_done(3);
      chk("stall_total_frames", frame_cnt, 32'd5);

      // keep CS across two commands
      run_cmd(2, 1'b1, 32'h0);
      wait_done(4);
      repeat (5) @(posedge SPICLK);
      @(negedge SPICLK);
      chk("keepcs_idle", {31'h0, bus.CSEXTEND}, 32'h1);
      run_cmd(2, 1'b0, 32'h0);
      wait_done(5);
      chk("keepcs_released", {31'h0, bus.CSEXTEND}, 32'h0);

      // slow TX stream: no start before the data is offered
      tx_delay = 20;
      latch_cyc.delete();
      valid_cyc.delete();
      run_cmd(3, 1'b0, 32'h0);
      wait_done(6);
      chk("slow_frames", latch_cyc.size(), 32'd3);
      for (int i = 0; i < latch_cyc.size() && i < valid_cyc.size(); i++)
         chk("start_after_data", {31'h0, latch_cyc[i] > valid_cyc[i]}, 32'h1);
      tx_delay = 0;

      // reset in the middle of word 2 of 4
      fc0 = frame_cnt;
      dn = done_cnt;
      run_cmd(4, 1'b0, 32'h0);
      t = 0;
      while (frame_cnt < fc0 + 2 && t < 2000) begin
         @(posedge SPICLK);
         t++;
      end
      chk("abort_reached_word2", frame_cnt, fc0 + 2);
      repeat (2) @(posedge SPICLK);
      @(negedge SPICLK); #2;
      SYSRSTB = 1'b0;
      #1 chk_all_zero("abort");
      tx_q.delete();
      exp_tx.delete();
      exp_cs.delete();
      exp_rx.delete();
      @(negedge SPICLK); #2 SYSRSTB = 1'b1;
      repeat (3) @(negedge SPICLK);
      chk("post_rst_rxs_valid", {31'h0, bus.RXS_VALID}, 32'h0);
      chk("post_rst_busy", {31'h0, bus.SEQBUSY}, 32'h0);
      frame_cnt = 0;
      run_cmd(1, 1'b0, 32'h0);
      wait_done(dn + 1);
      chk("post_rst_frames", frame_cnt, 32'd1);

      // randomized commands
      dn = done_cnt;
      for (int k = 0; k < 8; k++) begin
         rx_xor   = $urandom;
         tx_delay = $urandom_range(0, 3);
         rx_pct   = $urandom_range(30, 100);
         run_cmd($urandom_range(1, 6), 1'($urandom_range(0, 1)), 32'h0);
         wait_done(dn + k + 1);
      end
      chk("final_tx_consumed", exp_tx.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
